// File: rtl/cordic_vectorer.sv
// cordic_vectorer: pipelined vectoring-mode CORDIC, (x,y) -> (atan2 angle, gain-scaled magnitude).
// Accepts one sample per valid cycle with no backpressure; results emerge STAGES+2 cycles later.
module cordic_vectorer #(
    parameter int DATA_WIDTH  = 12,
    parameter int STAGES      = 12,
    parameter int ANGLE_WIDTH = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic signed [DATA_WIDTH-1:0]  y_in,
    output logic                          out_valid,
    output logic signed [ANGLE_WIDTH-1:0] angle_out,
    output logic        [DATA_WIDTH+1:0]  mag_out
);
    localparam int W  = DATA_WIDTH + 2;
    // fraction bits below the integer part keep shift truncation from eating angle accuracy
    localparam int G  = 6;
    localparam int IW = W + G;
    localparam int ATAN [16] = '{131072, 77376, 40884, 20753, 10417, 5213, 2607, 1304,
                                 652, 326, 163, 81, 41, 20, 10, 5};

    logic signed [W-1:0]           xe, ye;
    logic                          neg, zero;
    logic signed [IW-1:0]          xs [STAGES+1];
    logic signed [IW-1:0]          ys [STAGES+1];
    logic signed [ANGLE_WIDTH-1:0] zs [STAGES+1];
    logic        [STAGES:0]        vs, zf;

    assign xe   = W'(x_in);
    assign ye   = W'(y_in);
    assign neg  = x_in[DATA_WIDTH-1];
    assign zero = (x_in == '0) && (y_in == '0);

    // the origin would otherwise report the sum of all ATAN steps, so it is flagged alongside valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
            end
            vs        <= '0;
            zf        <= '0;
            out_valid <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
        end else begin
            xs[0] <= {neg ? -xe : xe, {G{1'b0}}};
            ys[0] <= {neg ? -ye : ye, {G{1'b0}}};
            zs[0] <= neg ? {1'b1, {(ANGLE_WIDTH-1){1'b0}}} : '0;
            vs    <= {vs[STAGES-1:0], in_valid};
            zf    <= {zf[STAGES-1:0], zero};
            for (int i = 0; i < STAGES; i++) begin
                xs[i+1] <= ys[i][IW-1] ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
                ys[i+1] <= ys[i][IW-1] ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
                zs[i+1] <= ys[i][IW-1] ? zs[i] - ANGLE_WIDTH'(ATAN[i]) : zs[i] + ANGLE_WIDTH'(ATAN[i]);
            end
            out_valid <= vs[STAGES];
            if (vs[STAGES]) begin
                angle_out <= zf[STAGES] ? '0 : zs[STAGES];
                mag_out   <= xs[STAGES][IW-1:G];
            end
        end
    end
endmodule
